// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I branch/jump encodings and redirect FSM states
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_JAL  = 2'b01;
  localparam logic [1:0] OP_JALR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_REDIR = 2'd2,
    S_FLUSH = 2'd3
  } redir_state_t;

endpackage

// File: rtl/branch_condition.sv
// rtl/branch_condition.sv - RV32I conditional branch comparator
module branch_condition
  import riscv_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  funct3,
  output logic        taken
);

  // Decode funct3 into the compare; reserved encodings never branch
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - branch/jump resolution, PC redirect and front-end flush sequencing
module branch_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_op,
  input  logic             kill,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             link_valid,
  output logic [31:0]      link_data,
  output logic             misalign_err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  redir_state_t state_q, state_d;

  logic [31:0] pc_q, rs1_q, rs2_q, imm_q;
  logic [2:0]  f3_q;
  logic [1:0]  op_q;
  logic [3:0]  flush_cnt_q;

  logic        cond_taken;
  logic        is_jump;
  logic        taken;
  logic        misaligned;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        accept;
  logic        redir_fire;

  branch_condition u_cond (
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .funct3 (f3_q),
    .taken  (cond_taken)
  );

  // Resolve the latched op: jumps always redirect, reserved op class never does
  always_comb begin
    is_jump    = (op_q == OP_JAL) || (op_q == OP_JALR);
    taken      = is_jump || ((op_q == OP_BR) && cond_taken);
    jalr_sum   = rs1_q + imm_q;
    target     = (op_q == OP_JALR) ? {jalr_sum[31:1], 1'b0} : (pc_q + imm_q);
    misaligned = (target[1:0] != 2'b00);
  end

  // Next-state and handshake outputs; kill overrides everything and forces IDLE
  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    accept         = 1'b0;
    redirect_valid = 1'b0;
    redir_fire     = 1'b0;
    flush          = 1'b0;
    link_valid     = 1'b0;
    misalign_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = !kill;
        accept   = in_valid && !kill;
        if (accept) state_d = S_EVAL;
      end
      S_EVAL: begin
        link_valid   = is_jump && !kill;
        misalign_err = taken && misaligned && !kill;
        state_d      = (taken && !misaligned) ? S_REDIR : S_IDLE;
      end
      S_REDIR: begin
        redirect_valid = !kill;
        redir_fire     = redirect_ready && !kill;
        if (redir_fire) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_q == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, redirect target, flush countdown and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
      f3_q         <= '0;
      op_q         <= '0;
      link_data    <= '0;
      redirect_pc  <= '0;
      flush_cnt_q  <= '0;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      if (accept) begin
        pc_q  <= in_pc;
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
        imm_q <= in_imm;
        f3_q  <= in_funct3;
        op_q  <= in_op;
        if ((in_op == OP_JAL) || (in_op == OP_JALR)) link_data <= in_pc + 32'd4;
      end
      if ((state_q == S_EVAL) && !kill) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if ((state_q == S_EVAL) && (state_d == S_REDIR)) begin
        redirect_pc <= target;
        taken_count <= taken_count + CNT_W'(1);
      end
      if (redir_fire) begin
        flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
      end else if ((state_q == S_FLUSH) && (flush_cnt_q != 4'd0)) begin
        flush_cnt_q <= flush_cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - randomized self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic [2:0]       in_funct3 = '0;
  logic [1:0]       in_op = '0;
  logic             kill = 1'b0;
  logic             redirect_valid;
  logic             redirect_ready = 1'b0;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             link_valid;
  logic [31:0]      link_data;
  logic             misalign_err;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_bc = '0;
  logic [31:0] exp_tc = '0;

  branch_redirect_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm         (in_imm),
    .in_funct3      (in_funct3),
    .in_op          (in_op),
    .kill           (kill),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .link_valid     (link_valid),
    .link_data      (link_data),
    .misalign_err   (misalign_err),
    .branch_count   (branch_count),
    .taken_count    (taken_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural outcome of one control-transfer op
  function automatic void ref_resolve(input logic [1:0] op, input logic [2:0] f3,
                                      input logic [31:0] pc, input logic [31:0] rs1,
                                      input logic [31:0] rs2, input logic [31:0] imm,
                                      output bit tk, output bit jump, output logic [31:0] tgt);
    bit signed_lt;
    signed_lt = $signed(rs1) < $signed(rs2);
    jump = (op == 2'b01) || (op == 2'b10);
    tk   = 1'b0;
    if (jump) tk = 1'b1;
    else if (op == 2'b00) begin
      case (f3)
        3'b000: tk = (rs1 == rs2);
        3'b001: tk = (rs1 != rs2);
        3'b100: tk = signed_lt;
        3'b101: tk = !signed_lt;
        3'b110: tk = (rs1 < rs2);
        3'b111: tk = !(rs1 < rs2);
        default: tk = 1'b0;
      endcase
    end
    if (op == 2'b10) tgt = (rs1 + imm) & 32'hFFFF_FFFE;
    else             tgt = pc + imm;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // Full transaction: accept, EVAL, optional held redirect for 'stall' cycles, flush, back to IDLE
  task automatic do_op(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [2:0] f3, input logic [1:0] op,
                       input int stall);
    bit tk, jump, mis;
    logic [31:0] tgt;
    ref_resolve(op, f3, pc, rs1, rs2, imm, tk, jump, tgt);
    mis = tk && (tgt[1:0] != 2'b00);
    wait_ready();
    in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_funct3 = f3; in_op = op;
    @(negedge clk);
    in_valid = 1'b0;
    in_pc = $urandom; in_rs1 = $urandom; in_rs2 = $urandom; in_imm = $urandom;
    #1;
    check_eq("eval_ready", {31'd0, in_ready}, 32'd0);
    check_eq("eval_link_valid", {31'd0, link_valid}, {31'd0, jump});
    if (jump) check_eq("eval_link_data", link_data, pc + 32'd4);
    check_eq("eval_misalign", {31'd0, misalign_err}, {31'd0, mis});
    check_eq("eval_rvalid", {31'd0, redirect_valid}, 32'd0);
    exp_bc++;
    @(negedge clk);
    if (tk && !mis) begin
      exp_tc++;
      for (int i = 0; i < stall; i++) begin
        check_eq("redir_valid_hold", {31'd0, redirect_valid}, 32'd1);
        check_eq("redir_pc_hold", redirect_pc, tgt);
        check_eq("redir_no_flush", {31'd0, flush}, 32'd0);
        check_eq("redir_not_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
      end
      check_eq("redir_valid", {31'd0, redirect_valid}, 32'd1);
      check_eq("redir_pc", redirect_pc, tgt);
      redirect_ready = 1'b1;
      @(negedge clk);
      redirect_ready = 1'b0;
      for (int f = 0; f < FLUSH_CYCLES; f++) begin
        check_eq("flush_high", {31'd0, flush}, 32'd1);
        check_eq("flush_rvalid", {31'd0, redirect_valid}, 32'd0);
        @(negedge clk);
      end
    end
    check_eq("idle_ready", {31'd0, in_ready}, 32'd1);
    check_eq("idle_flush", {31'd0, flush}, 32'd0);
    check_eq("branch_count", branch_count, exp_bc);
    check_eq("taken_count", taken_count, exp_tc);
  endtask

  // Taken BEQ killed either while holding the redirect (stage 0) or in its first flush cycle (stage 1)
  task automatic kill_test(input int stage);
    wait_ready();
    in_valid = 1'b1; in_pc = 32'h300; in_rs1 = 32'd7; in_rs2 = 32'd7;
    in_imm = 32'h8; in_funct3 = 3'b000; in_op = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    exp_bc++;
    @(negedge clk);
    exp_tc++;
    check_eq("kill_pre_rvalid", {31'd0, redirect_valid}, 32'd1);
    if (stage == 1) begin
      redirect_ready = 1'b1;
      @(negedge clk);
      redirect_ready = 1'b0;
      check_eq("kill_pre_flush", {31'd0, flush}, 32'd1);
    end else begin
      redirect_ready = 1'b1;
    end
    kill = 1'b1;
    #1;
    check_eq("kill_rvalid_low", {31'd0, redirect_valid}, 32'd0);
    check_eq("kill_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    kill = 1'b0;
    redirect_ready = 1'b0;
    #1;
    check_eq("kill_idle_ready", {31'd0, in_ready}, 32'd1);
    check_eq("kill_idle_flush", {31'd0, flush}, 32'd0);
    check_eq("kill_idle_rvalid", {31'd0, redirect_valid}, 32'd0);
    check_eq("kill_taken_count", taken_count, exp_tc);
    check_eq("kill_branch_count", branch_count, exp_bc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rvalid"}, {31'd0, redirect_valid}, 32'd0);
    check_eq({tag, "_flush"}, {31'd0, flush}, 32'd0);
    check_eq({tag, "_link_valid"}, {31'd0, link_valid}, 32'd0);
    check_eq({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
    check_eq({tag, "_rpc"}, redirect_pc, 32'd0);
    check_eq({tag, "_link_data"}, link_data, 32'd0);
    check_eq({tag, "_bcount"}, branch_count, 32'd0);
    check_eq({tag, "_tcount"}, taken_count, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    // BEQ taken
    do_op(32'h100, 32'd5, 32'd5, 32'h20, 3'b000, 2'b00, 0);
    // BLT vs BLTU with rs1 = -1
    do_op(32'h140, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'b100, 2'b00, 0);
    do_op(32'h140, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'b110, 2'b00, 0);
    // JALR misaligned, then aligned after bit-0 clear
    do_op(32'h200, 32'h1003, 32'd0, 32'd0, 3'b000, 2'b10, 0);
    do_op(32'h200, 32'h1001, 32'd0, 32'd0, 3'b000, 2'b10, 0);
    // Backpressure on the redirect
    do_op(32'h400, 32'd1, 32'd2, 32'h10, 3'b001, 2'b00, 5);
    // Target wrap
    do_op(32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20, 3'b000, 2'b01, 0);
    // Reserved op class behaves as not-taken
    do_op(32'h500, 32'd3, 32'd3, 32'h8, 3'b000, 2'b11, 0);
    // Reserved funct3 never branches
    do_op(32'h500, 32'd3, 32'd3, 32'h8, 3'b010, 2'b00, 0);

    kill_test(0);
    kill_test(1);

    // kill blocks acceptance in IDLE
    in_valid = 1'b1; in_op = 2'b01; in_pc = 32'h600; in_imm = 32'h10;
    kill = 1'b1;
    #1;
    check_eq("kill_blocks_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    kill = 1'b0;
    #1;
    check_eq("kill_blocks_accept", {31'd0, in_ready}, 32'd1);
    check_eq("kill_blocks_link", {31'd0, link_valid}, 32'd0);

    // Randomized ops against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] r1, r2, im;
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 32'($urandom);
      if ($urandom_range(0, 1) == 1) r1 = {28'd0, r1[3:0]};
      im = $urandom_range(0, 3) == 0 ? 32'($urandom) : {{20{1'b0}}, 12'($urandom)} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) im = im | 32'd2;
      do_op(32'($urandom) & 32'hFFFF_FFFC, r1, r2, im, 3'($urandom), 2'($urandom),
            int'($urandom_range(0, 3)));
    end

    // Reset during EVAL abandons the op
    wait_ready();
    in_valid = 1'b1; in_pc = 32'h700; in_rs1 = 32'd0; in_imm = 32'h40;
    in_funct3 = 3'b000; in_op = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_eval");
    exp_bc = '0;
    exp_tc = '0;
    @(negedge clk);
    check_eq("rst_no_redirect", {31'd0, redirect_valid}, 32'd0);
    do_op(32'h800, 32'd9, 32'd4, 32'h4, 3'b101, 2'b00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequencing controller for the branch-condition comparator in the RV32I core.
- Accepts one control-transfer op at a time from decode over a valid/ready handshake: BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL or JALR.
- Registers the operands, resolves the condition through an internal comparator instance and computes the target. When taken, it issues a held PC redirect followed by a fixed-length front-end flush; it also keeps taken/executed statistics.

Parameters:
- FLUSH_CYCLES, 2, cycles `flush` stays high after a redirect is accepted (legal range 1..15)
- CNT_W, 32, width of the statistics counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an op
- in_ready  out  1  controller can accept an op
- in_pc  in  32  PC of the op
- in_rs1  in  32  rs1 operand
- in_rs2  in  32  rs2 operand
- in_imm  in  32  sign-extended immediate
- in_funct3  in  3  branch funct3
- in_op  in  2  op class: 00 = conditional branch, 01 = JAL, 10 = JALR, 11 = reserved
- kill  in  1  trap/exception abort from the commit stage
- redirect_valid  out  1  new PC request
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  32  target PC
- flush  out  1  squash the fetch/decode stages
- link_valid  out  1  one-cycle pulse: write `link_data` to rd
- link_data  out  32  pc+4 of a JAL/JALR op
- misalign_err  out  1  one-cycle pulse: taken target not 4-byte aligned
- branch_count  out  CNT_W  resolved ops (branches and jumps)
- taken_count  out  CNT_W  redirects issued

Behaviour:
- **State machine.** States IDLE, EVAL, REDIR, FLUSH, encoded 2 bits.
- **Reset.** On reset: state=IDLE; all 1-bit outputs 0; `redirect_pc`, `link_data` and both counters 0. Reset mid-operation abandons the op immediately with no redirect.
- **Ready.** `in_ready` = (state==IDLE) && !kill.
- **Accept.** The handshake fires when `in_valid` && `in_ready` in IDLE. At that edge the controller latches pc, rs1, rs2, imm, funct3 and op, then moves to EVAL. `in_op` = 11 is accepted and treated as a not-taken branch.
- **Taken rules (EVAL).** Conditional branch: taken = comparator output. JAL/JALR: always taken. Comparator semantics:
  - funct3 000 BEQ, 001 BNE
  - 100 BLT, 101 BGE (signed)
  - 110 BLTU, 111 BGEU (unsigned)
  - 010 and 011 give not-taken
- **Target (EVAL).** Branch and JAL: pc+imm. JALR: (rs1+imm) with bit 0 cleared. All sums are modulo 2^32 and wrap silently.
- **JAL/JALR link.** In EVAL, `link_valid` pulses for one cycle with `link_data` = pc+4, independent of misalignment.
- **EVAL → IDLE.** Taken = 0 or misaligned target: go to IDLE. If misaligned (target[1:0] != 0), `misalign_err` pulses for one cycle and no redirect is issued.
- **EVAL → REDIR.** Taken and aligned: go to REDIR with `redirect_pc` registered.
- **Counters (EVAL).** `branch_count` increments once per EVAL. `taken_count` increments on entry to REDIR. Both wrap at 2^CNT_W.
- **REDIR.** `redirect_valid` = 1. `redirect_pc` is stable until `redirect_valid` && `redirect_ready` fires. On that handshake, go to FLUSH with the flush counter = FLUSH_CYCLES-1.
- **FLUSH.** `flush` = 1 while in FLUSH. The counter decrements each cycle; at 0 go to IDLE. A new op may be accepted on the first IDLE cycle.
- **Latency.** Accept edge = T:
  - EVAL during cycle T+1
  - `redirect_valid` earliest in cycle T+2
  - with `redirect_ready` tied high: `flush` high for cycles T+3 .. T+2+FLUSH_CYCLES; `in_ready` again at T+3+FLUSH_CYCLES
  - not-taken op: `in_ready` again at T+2
- **kill.** Highest priority. In any state, next state = IDLE. In that same cycle `redirect_valid`, `link_valid`, `misalign_err` and counter increments are suppressed, and no op is accepted while `kill` is high. An in-progress FLUSH is truncated; the trap logic owns the front end.
- **Simultaneous events.** `redirect_ready` together with `kill`: kill wins and the redirect is not counted as accepted. `in_valid` while busy: ignored; decode must hold the op (standard valid/ready).

Decomposition:
- Shared package `riscv_pkg` holds:
  - funct3 constants F3_BEQ..F3_BGEU
  - op-class constants OP_BR, OP_JAL, OP_JALR
  - the FSM state encoding
- Natural sub-module: instantiate the existing `branch_condition` comparator, driven by the latched rs1/rs2/funct3. No other sub-modules; the FSM, target adder and counters are local.

Test Plan:
- **BEQ taken.** pc=0x100, rs1=rs2=5, imm=0x20, op=00, f3=000, `redirect_ready`=1 → `redirect_pc`=0x120 at T+2; `flush` high 2 cycles; `taken_count`=1, `branch_count`=1.
- **BLT vs BLTU.** rs1=0xFFFF_FFFF, rs2=1: f3=100 → taken; f3=110 → not taken, no redirect, `in_ready` back at T+2, `taken_count` unchanged.
- **JALR.** pc=0x200, rs1=0x1003, imm=0 → `link_valid` pulse with `link_data`=0x204; `redirect_pc`=0x1002 → `misalign_err` pulse, no redirect; repeat with rs1=0x1001 → redirect to 0x1000.
- **Backpressure.** `redirect_ready`=0 for 5 cycles → `redirect_valid` and `redirect_pc` stable, `in_ready`=0 throughout, `flush` starts only after the handshake.
- **kill.** Assert `kill` in REDIR and, separately, in the first FLUSH cycle → IDLE next cycle, `redirect_valid` low, `taken_count` reflects only the EVAL increment.
- **rst and wrap.** `rst` in EVAL → all outputs 0, IDLE. Separately: pc=0xFFFF_FFF0, imm=0x20 → `redirect_pc`=0x0000_0010.
